// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared rounding-mode encoding and exponent constant helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    function automatic int unsigned exp_fill(input int unsigned width, input logic ones);
        return ones ? ((32'd1 << width) - 32'd1) : 32'd0;
    endfunction

    function automatic int unsigned exp_all_ones(input int unsigned width);
        return exp_fill(width, 1'b1);
    endfunction

    function automatic int unsigned exp_zero(input int unsigned width);
        return exp_fill(width, 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_round_decide.sv
`default_nettype none
// ============================================================================
// Module      : fpu_round_decide
// Description : Combinational round-increment and inexact decision.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_round_decide
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       round_bit,
    input  logic       sticky,
    input  logic [2:0] rm,
    output logic       inc,
    output logic       inexact
);

    always_comb begin
        inexact = guard | round_bit | sticky;
        inc     = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & inexact;
            RM_RUP:  inc = ~sign & inexact;
            RM_RMM:  inc = guard;
            // unused encodings 5..7 fall back to round-to-nearest-even
            default: inc = guard & (round_bit | sticky | lsb);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fpu_round_pipe
// Description : Two-stage stallable IEEE 754 rounding stage with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_round_pipe
    import fpu_pkg::*;
#(
    parameter int EXPONENT_WIDTH    = 11,
    parameter int SIGNIFICAND_WIDTH = 52
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [EXPONENT_WIDTH-1:0]    in_exponent,
    input  logic [SIGNIFICAND_WIDTH:0]   in_significand,
    input  logic                         in_guard,
    input  logic                         in_round,
    input  logic                         in_sticky,
    input  logic [2:0]                   in_rm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sign,
    output logic [EXPONENT_WIDTH-1:0]    out_exponent,
    output logic [SIGNIFICAND_WIDTH:0]   out_significand,
    output logic                         out_inexact,
    output logic                         out_overflow
);

    localparam logic [EXPONENT_WIDTH-1:0]  c_EXP_ONES  = EXPONENT_WIDTH'(exp_all_ones(EXPONENT_WIDTH));
    localparam logic [EXPONENT_WIDTH-1:0]  c_EXP_ZERO  = EXPONENT_WIDTH'(exp_zero(EXPONENT_WIDTH));
    localparam logic [EXPONENT_WIDTH-1:0]  c_EXP_ONE   = EXPONENT_WIDTH'(1);
    localparam logic [SIGNIFICAND_WIDTH:0] c_SIG_CARRY = {1'b1, {SIGNIFICAND_WIDTH{1'b0}}};

    logic                         w_s1_en;
    logic                         w_s2_en;
    logic                         w_special;
    logic                         w_inc_raw;
    logic                         w_inexact_raw;

    logic                         r_s1_valid;
    logic                         r_s1_sign;
    logic [EXPONENT_WIDTH-1:0]    r_s1_exp;
    logic [SIGNIFICAND_WIDTH:0]   r_s1_sig;
    logic                         r_s1_inc;
    logic                         r_s1_inexact;
    logic                         r_s1_special;

    logic [SIGNIFICAND_WIDTH+1:0] w_sum;
    logic [EXPONENT_WIDTH-1:0]    w_res_exp;
    logic [SIGNIFICAND_WIDTH:0]   w_res_sig;
    logic                         w_res_inexact;
    logic                         w_res_overflow;

    logic                         r_s2_valid;
    logic                         r_s2_sign;
    logic [EXPONENT_WIDTH-1:0]    r_s2_exp;
    logic [SIGNIFICAND_WIDTH:0]   r_s2_sig;
    logic                         r_s2_inexact;
    logic                         r_s2_overflow;

    assign w_s2_en   = ~r_s2_valid | out_ready;
    assign w_s1_en   = ~r_s1_valid | w_s2_en;
    assign in_ready  = w_s1_en;
    assign w_special = (in_exponent == c_EXP_ONES);

    fpu_round_decide u_decide (
        .sign      (in_sign),
        .lsb       (in_significand[0]),
        .guard     (in_guard),
        .round_bit (in_round),
        .sticky    (in_sticky),
        .rm        (in_rm),
        .inc       (w_inc_raw),
        .inexact   (w_inexact_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_sig     <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
            r_s1_special <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign    <= in_sign;
                r_s1_exp     <= in_exponent;
                r_s1_sig     <= in_significand;
                // Inf/NaN operands pass through untouched and unflagged
                r_s1_inc     <= w_inc_raw & ~w_special;
                r_s1_inexact <= w_inexact_raw & ~w_special;
                r_s1_special <= w_special;
            end
        end
    end

    assign w_sum = {1'b0, r_s1_sig} + {{(SIGNIFICAND_WIDTH+1){1'b0}}, r_s1_inc};

    always_comb begin
        w_res_exp      = r_s1_exp;
        w_res_sig      = r_s1_sig;
        w_res_inexact  = 1'b0;
        w_res_overflow = 1'b0;
        if (!r_s1_special) begin
            w_res_inexact = r_s1_inexact;
            if (w_sum[SIGNIFICAND_WIDTH+1]) begin
                w_res_exp = r_s1_exp + c_EXP_ONE;
                w_res_sig = c_SIG_CARRY;
            end else begin
                w_res_sig = w_sum[SIGNIFICAND_WIDTH:0];
                // subnormal rounded up into the normal range
                if ((r_s1_exp == c_EXP_ZERO) && w_sum[SIGNIFICAND_WIDTH])
                    w_res_exp = c_EXP_ONE;
            end
            if (w_res_exp == c_EXP_ONES) begin
                w_res_sig      = '0;
                w_res_overflow = 1'b1;
                w_res_inexact  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_s2_sign     <= 1'b0;
            r_s2_exp      <= '0;
            r_s2_sig      <= '0;
            r_s2_inexact  <= 1'b0;
            r_s2_overflow <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign     <= r_s1_sign;
                r_s2_exp      <= w_res_exp;
                r_s2_sig      <= w_res_sig;
                r_s2_inexact  <= w_res_inexact;
                r_s2_overflow <= w_res_overflow;
            end
        end
    end

    assign out_valid       = r_s2_valid;
    assign out_sign        = r_s2_sign;
    assign out_exponent    = r_s2_exp;
    assign out_significand = r_s2_sig;
    assign out_inexact     = r_s2_inexact;
    assign out_overflow    = r_s2_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_round_pipe
// Description : Self-checking bench for fpu_round_pipe (EW=5, SW=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_round_pipe;

    localparam int EW       = 5;
    localparam int SW       = 10;
    localparam int EXP_ONES = (1 << EW) - 1;
    localparam int HIDDEN   = 1 << SW;
    localparam int SIG_WRAP = 1 << (SW + 1);

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] e;
        logic [SW:0]   m;
        logic          inx;
        logic          ovf;
    } res_t;

    typedef struct {
        logic sign;
        int   e;
        int   m;
        logic g;
        logic r;
        logic s;
        int   rm;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exponent;
    logic [SW:0]   in_significand;
    logic          in_guard;
    logic          in_round;
    logic          in_sticky;
    logic [2:0]    in_rm;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exponent;
    logic [SW:0]   out_significand;
    logic          out_inexact;
    logic          out_overflow;

    always #5 clk = ~clk;

    fpu_round_pipe #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(SW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sign         (in_sign),
        .in_exponent     (in_exponent),
        .in_significand  (in_significand),
        .in_guard        (in_guard),
        .in_round        (in_round),
        .in_sticky       (in_sticky),
        .in_rm           (in_rm),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sign        (out_sign),
        .out_exponent    (out_exponent),
        .out_significand (out_significand),
        .out_inexact     (out_inexact),
        .out_overflow    (out_overflow)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   out_cyc = 0;
    int   n_out = 0;
    res_t q[$];
    res_t last_out;
    res_t prev_cur;
    logic hold_prev = 1'b0;
    logic acc_last = 1'b0;
    logic last_in_ready = 1'b0;
    op_t  cur_op;

    // Reference: exact value in eighths of an ulp, rounded per mode with plain integers
    function automatic res_t model(input op_t op);
        res_t o;
        int   rem, n, e;
        bit   up;
        o.sign = op.sign;
        if (op.e == EXP_ONES) begin
            o.e = EW'(op.e); o.m = (SW+1)'(op.m); o.inx = 1'b0; o.ovf = 1'b0;
            return o;
        end
        rem = (op.g ? 4 : 0) + (op.r ? 2 : 0) + (op.s ? 1 : 0);
        case (op.rm)
            1:       up = 1'b0;
            2:       up = op.sign && rem > 0;
            3:       up = !op.sign && rem > 0;
            4:       up = rem >= 4;
            default: up = rem > 4 || (rem == 4 && (op.m % 2) == 1);
        endcase
        n = op.m + (up ? 1 : 0);
        e = op.e;
        if (n >= SIG_WRAP) begin
            n = n / 2;
            e = e + 1;
        end else if (e == 0 && n >= HIDDEN) begin
            e = 1;
        end
        o.inx = rem > 0;
        o.ovf = 1'b0;
        if (e == EXP_ONES) begin
            n = 0; o.ovf = 1'b1; o.inx = 1'b1;
        end
        o.e = EW'(e);
        o.m = (SW+1)'(n);
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input op_t op);
        cur_op         = op;
        in_sign        = op.sign;
        in_exponent    = EW'(op.e);
        in_significand = (SW+1)'(op.m);
        in_guard       = op.g;
        in_round       = op.r;
        in_sticky      = op.s;
        in_rm          = 3'(op.rm);
    endtask

    task automatic step();
        res_t cur;
        @(negedge clk);
        cur = {out_sign, out_exponent, out_significand, out_inexact, out_overflow};
        acc_last      = 1'b0;
        last_in_ready = in_ready;
        if (!rst) begin
            if (hold_prev) check("hold_stable", 32'(cur), 32'(prev_cur));
            if (in_valid && in_ready) begin
                q.push_back(model(cur_op));
                acc_last = 1'b1;
                acc_cyc  = cyc;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(cur), 32'h0);
                    check("unexpected_out_valid", 32'(out_valid), 32'h0);
                end else begin
                    check("result", 32'(cur), 32'(q.pop_front()));
                end
                last_out = cur;
                out_cyc  = cyc;
                n_out++;
            end
            hold_prev = out_valid && !out_ready;
            prev_cur  = cur;
        end else begin
            hold_prev = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_t op);
        int k;
        drive(op);
        in_valid = 1'b1;
        for (k = 0; k < 30; k++) begin
            step();
            if (acc_last) break;
        end
        in_valid = 1'b0;
        if (k == 30) check("send_timeout", 32'(k), 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() > 0; k++) step();
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic directed(input string tag, input logic sg, input int e, input int m,
                            input logic g, input logic r, input logic s, input int rm,
                            input int ee, input int em, input logic ei, input logic eo);
        op_t  op;
        res_t want;
        op = '{sign: sg, e: e, m: m, g: g, r: r, s: s, rm: rm};
        out_ready = 1'b1;
        send(op);
        drain();
        want = {sg, EW'(ee), (SW+1)'(em), ei, eo};
        check(tag, 32'(last_out), 32'(want));
    endtask

    function automatic op_t rand_op();
        op_t op;
        int  sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       op.e = 0;
            1:       op.e = EXP_ONES - 1;
            2:       op.e = EXP_ONES;
            3:       op.e = EXP_ONES - 2;
            default: op.e = $urandom_range(1, EXP_ONES - 1);
        endcase
        op.m    = ($urandom_range(0, 3) == 0) ? (SIG_WRAP - 1) : $urandom_range(0, SIG_WRAP - 1);
        op.sign = 1'($urandom_range(0, 1));
        op.g    = 1'($urandom_range(0, 1));
        op.r    = 1'($urandom_range(0, 1));
        op.s    = 1'($urandom_range(0, 1));
        op.rm   = $urandom_range(0, 7);
        return op;
    endfunction

    initial begin
        op_t  op;
        logic saw_low;
        int   n_before;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '{sign: 1'b0, e: 1, m: HIDDEN, g: 1'b0, r: 1'b0, s: 1'b0, rm: 0};
        drive(op);
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", 32'({out_sign, out_exponent, out_significand, out_inexact, out_overflow}), 32'd0);

        directed("rne_tie_odd",   0, 10, 'h401, 1, 0, 0, 0, 10, 'h402, 1, 0);
        directed("rne_tie_even",  0, 10, 'h400, 1, 0, 0, 0, 10, 'h400, 1, 0);
        directed("rne_exact",     0, 10, 'h400, 0, 0, 0, 0, 10, 'h400, 0, 0);
        directed("rne_carry",     0, 14, 'h7FF, 1, 0, 0, 0, 15, 'h400, 1, 0);
        directed("rup_overflow",  0, 30, 'h7FF, 1, 0, 0, 3, 31, 'h000, 1, 1);
        directed("rtz_no_ovf",    0, 30, 'h7FF, 1, 0, 0, 1, 30, 'h7FF, 1, 0);
        directed("sub_promote",   0, 0,  'h3FF, 1, 0, 0, 3, 1,  'h400, 1, 0);
        directed("sub_rdn_pos",   0, 0,  'h3FF, 1, 0, 0, 2, 0,  'h3FF, 1, 0);
        directed("rm7_as_rne",    0, 10, 'h401, 1, 0, 0, 7, 10, 'h402, 1, 0);
        directed("rmm_neg_tie",   1, 10, 'h400, 1, 0, 0, 4, 10, 'h401, 1, 0);
        directed("rdn_neg_stk",   1, 10, 'h400, 0, 0, 1, 2, 10, 'h401, 1, 0);
        directed("rup_neg_stk",   1, 10, 'h400, 0, 0, 1, 3, 10, 'h400, 1, 0);

        // six back-to-back ops with a three-cycle downstream stall in the middle
        saw_low  = 1'b0;
        n_before = n_out;
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 40 && sent < 6; c++) begin
                if (!in_valid || acc_last) begin
                    op = rand_op();
                    op.e = $urandom_range(1, EXP_ONES - 2);
                    drive(op);
                end
                in_valid  = 1'b1;
                out_ready = !(c >= 3 && c <= 5);
                step();
                if (!out_ready && !last_in_ready) saw_low = 1'b1;
                if (acc_last) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp_sent", 32'(sent), 32'd6);
        end
        drain();
        check("bp_in_ready_low", 32'(saw_low), 32'd1);
        check("bp_out_count", 32'(n_out - n_before), 32'd6);

        // fill both stages, then reset with everything in flight
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            op = rand_op();
            op.e = $urandom_range(1, EXP_ONES - 2);
            drive(op);
            in_valid = 1'b1;
            step();
            if (!last_in_ready) break;
        end
        check("full_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        q.delete();
        hold_prev = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_outputs", 32'({out_sign, out_exponent, out_significand, out_inexact, out_overflow}), 32'd0);
        directed("post_rst_op",   0, 10, 'h401, 1, 0, 0, 0, 10, 'h402, 1, 0);
        check("latency", 32'(out_cyc - acc_cyc), 32'd2);
        directed("inf_pass",      0, 31, 'h000, 1, 1, 1, 3, 31, 'h000, 0, 0);
        directed("nan_pass",      1, 31, 'h5AB, 1, 0, 1, 0, 31, 'h5AB, 0, 0);

        // randomized traffic with random backpressure against the model
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc_last) begin
                drive(rand_op());
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
